huffman_freq_counter: RTL and testbench

Symbol-histogram stage of the canonical Huffman encoder. It consumes the byte stream produced by the block serializer: one byte per enable cycle, 20 bytes per block. It accumulates a per-symbol occurrence count over each block. It then emits the non-zero (symbol, count) pairs in ascending symbol order over a ready/valid interface to the code-length/tree-build stage.

---
 rtl/huffman_pkg.sv | 19 +
 rtl/huffman_freq_counter_if.sv | 30 +++
 rtl/huffman_hist_ram.sv | 38 +++
 rtl/huffman_freq_counter.sv | 145 ++++++++++++++
 tb/tb_huffman_freq_counter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the canonical Huffman encoder stages: default widths,
// the histogram FSM states and the (symbol, count) pair handed to tree build.
package huffman_pkg;

    localparam int SYM_W_DEFAULT     = 8;
    localparam int BLOCK_LEN_DEFAULT = 20;
    localparam int CNT_W_DEFAULT     = 5;

    typedef enum logic {
        COUNT = 1'b0,
        SCAN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [SYM_W_DEFAULT-1:0] sym;
        logic [CNT_W_DEFAULT-1:0] cnt;
    } pair_t;

endpackage

// File: rtl/huffman_freq_counter_if.sv
// Byte-in / pair-out bundle of the symbol-histogram stage; the histogram block
// uses the master view, the serializer/tree-build side uses the slave view.
interface huffman_freq_counter_if
    import huffman_pkg::*;
#(
    parameter int SYM_W = SYM_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic             in_enb;
    logic [SYM_W-1:0] in_data;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [SYM_W-1:0] out_sym;
    logic [CNT_W-1:0] out_cnt;
    logic             out_last;
    logic [SYM_W:0]   distinct;

    modport master (
        input  in_enb, in_data, out_ready,
        output busy, out_valid, out_sym, out_cnt, out_last, distinct
    );

    modport slave (
        output in_enb, in_data, out_ready,
        input  busy, out_valid, out_sym, out_cnt, out_last, distinct
    );

endinterface

// File: rtl/huffman_hist_ram.sv
// Per-symbol occurrence counters: increment port with was-zero flag for the
// counting phase, combinational read plus clear for the scan phase.
module huffman_hist_ram #(
    parameter int SYM_W = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [SYM_W-1:0] inc_addr,
    output logic             was_zero,
    input  logic             clr_en,
    input  logic [SYM_W-1:0] rd_addr,
    output logic [CNT_W-1:0] rd_data
);

    logic [CNT_W-1:0] hist [2**SYM_W];

    assign was_zero = (hist[inc_addr] == '0);
    assign rd_data  = hist[rd_addr];

    // Increment and clear belong to different FSM phases, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**SYM_W; i++) begin
                hist[i] <= '0;
            end
        end else begin
            if (inc_en) begin
                hist[inc_addr] <= hist[inc_addr] + 1'b1;
            end
            if (clr_en) begin
                hist[rd_addr] <= '0;
            end
        end
    end

endmodule

// File: rtl/huffman_freq_counter.sv
// Symbol histogram over fixed-length blocks, emitted as ascending (sym, count)
// pairs. Define HUFF_FREQ_DROP_ERR_EN to add a sticky drop_err output.
module huffman_freq_counter
    import huffman_pkg::*;
#(
    parameter int SYM_W     = SYM_W_DEFAULT,
    parameter int BLOCK_LEN = BLOCK_LEN_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    huffman_freq_counter_if.master  bus
`ifdef HUFF_FREQ_DROP_ERR_EN
    ,
    output logic                    drop_err
`endif
);

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(BLOCK_LEN - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] sample_cnt;
    logic [SYM_W:0]   idx;
    logic [SYM_W:0]   emitted;
    logic [SYM_W:0]   distinct;

    logic             pair_valid;
    logic             pair_last;
    logic [SYM_W-1:0] pair_sym;
    logic [CNT_W-1:0] pair_cnt;

    logic             was_zero;
    logic [CNT_W-1:0] rd_data;
    logic             accept;
    logic             slot_free;
    logic             last_hs;
    logic             examine;
    logic             hit;

    huffman_hist_ram #(
        .SYM_W (SYM_W),
        .CNT_W (CNT_W)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (accept),
        .inc_addr (bus.in_data),
        .was_zero (was_zero),
        .clr_en   (hit),
        .rd_addr  (idx[SYM_W-1:0]),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COUNT;
        end else begin
            state <= next_state;
        end
    end

    // The pointer stops at the alphabet end; the final handshake itself never
    // examines, since every remaining entry is known to be zero.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        examine    = 1'b0;
        hit        = 1'b0;
        slot_free  = !pair_valid || bus.out_ready;
        last_hs    = pair_valid && pair_last && bus.out_ready;
        case (state)
            COUNT: begin
                accept = bus.in_enb;
                if (bus.in_enb && (sample_cnt == LAST_SAMPLE)) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                examine = slot_free && !last_hs && !idx[SYM_W];
                hit     = examine && (rd_data != '0);
                if (last_hs) begin
                    next_state = COUNT;
                end
            end
            default: next_state = COUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt <= '0;
            idx        <= '0;
            emitted    <= '0;
            distinct   <= '0;
            pair_valid <= 1'b0;
            pair_last  <= 1'b0;
            pair_sym   <= '0;
            pair_cnt   <= '0;
        end else begin
            if (accept) begin
                sample_cnt <= (sample_cnt == LAST_SAMPLE) ? '0 : sample_cnt + 1'b1;
                if (was_zero) begin
                    distinct <= distinct + 1'b1;
                end
            end
            if (last_hs) begin
                idx        <= '0;
                emitted    <= '0;
                distinct   <= '0;
                pair_valid <= 1'b0;
                pair_last  <= 1'b0;
            end else if ((state == SCAN) && slot_free) begin
                pair_valid <= hit;
                if (examine) begin
                    idx <= idx + 1'b1;
                end
                if (hit) begin
                    pair_sym  <= idx[SYM_W-1:0];
                    pair_cnt  <= rd_data;
                    pair_last <= ((emitted + 1'b1) == distinct);
                    emitted   <= emitted + 1'b1;
                end
            end
        end
    end

`ifdef HUFF_FREQ_DROP_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_err <= 1'b0;
        end else if ((state == SCAN) && bus.in_enb) begin
            drop_err <= 1'b1;
        end
    end
`endif

    assign bus.busy      = (state == SCAN);
    assign bus.out_valid = pair_valid;
    assign bus.out_sym   = pair_sym;
    assign bus.out_cnt   = pair_cnt;
    assign bus.out_last  = pair_last;
    assign bus.distinct  = distinct;

endmodule

// File: tb/tb_huffman_freq_counter.sv
// Self-checking bench for huffman_freq_counter: directed vector table, random
// blocks against a histogram reference model, drop and mid-scan reset sequences.
module tb_huffman_freq_counter;
    import huffman_pkg::*;

    typedef struct {
        logic [7:0] data [20];
        int         ready_mode;
        int         exp_pairs;
        int         exp_first_sym;
        int         exp_first_cnt;
        int         exp_first_lat;
        int         exp_last_sym;
        int         exp_last_cnt;
        int         exp_distinct;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    huffman_freq_counter_if #(.SYM_W(8), .CNT_W(5)) bus ();

`ifdef HUFF_FREQ_DROP_ERR_EN
    logic drop_err;
`endif

    huffman_freq_counter #(
        .SYM_W     (8),
        .BLOCK_LEN (20),
        .CNT_W     (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef HUFF_FREQ_DROP_ERR_EN
        ,
        .drop_err (drop_err)
`endif
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    int    first_valid;
    bit    last_seen;
    pair_t got[$];
    int    got_cyc[$];
    bit    got_last[$];
    pair_t exp_q[$];
    vec_t  vecs [4];

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Called at a falling edge with inputs already set; records the handshake of
    // the coming rising edge and verifies that stalled pairs stay put.
    task automatic cycle();
        bit         hold;
        logic [7:0] h_sym;
        logic [4:0] h_cnt;
        logic       h_last;
        pair_t      p;
        if (bus.out_valid && bus.out_ready) begin
            p.sym = bus.out_sym;
            p.cnt = bus.out_cnt;
            got.push_back(p);
            got_cyc.push_back(cyc);
            got_last.push_back(bus.out_last);
            if (bus.out_last) last_seen = 1'b1;
        end
        hold   = bus.out_valid && !bus.out_ready;
        h_sym  = bus.out_sym;
        h_cnt  = bus.out_cnt;
        h_last = bus.out_last;
        @(negedge clk);
        cyc++;
        if (hold) begin
            check_output("hold_valid", int'(bus.out_valid), 1);
            check_output("hold_sym", int'(bus.out_sym), int'(h_sym));
            check_output("hold_cnt", int'(bus.out_cnt), int'(h_cnt));
            check_output("hold_last", int'(bus.out_last), int'(h_last));
        end
    endtask

    // Reference: a block's output is every symbol with a non-zero count, ascending.
    function automatic int model_block(input logic [7:0] data [20]);
        int    hist [256];
        pair_t p;
        foreach (hist[s]) hist[s] = 0;
        foreach (data[i]) hist[data[i]]++;
        exp_q.delete();
        for (int s = 0; s < 256; s++) begin
            if (hist[s] != 0) begin
                p.sym = 8'(s);
                p.cnt = 5'(hist[s]);
                exp_q.push_back(p);
            end
        end
        return exp_q.size();
    endfunction

    task automatic apply_stimulus(input logic [7:0] data [20], input int mode, input bit inject,
                                  input int exp_distinct, output int c_last);
        got.delete();
        got_cyc.delete();
        got_last.delete();
        first_valid   = -1;
        last_seen     = 1'b0;
        c_last        = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_enb  = 1'b1;
            bus.in_data = data[i];
            if (i == 19) c_last = cyc;
            cycle();
        end
        bus.in_enb = 1'b0;
        check_output("busy_after_block", int'(bus.busy), 1);
        check_output("distinct", int'(bus.distinct), exp_distinct);
        for (int n = 0; n < 400 && !last_seen; n++) begin
            bus.in_enb = 1'b0;
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = n[0];
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject && (n % 3 == 0)) begin
                bus.in_enb  = 1'b1;
                bus.in_data = 8'hEE;
            end
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            cycle();
        end
        bus.in_enb    = 1'b0;
        bus.out_ready = 1'b1;
        check_output("scan_done", int'(last_seen), 1);
        check_output("busy_released", int'(bus.busy), 0);
        check_output("distinct_cleared", int'(bus.distinct), 0);
    endtask

    task automatic compare_model(input int c_last, input int mode);
        int n;
        check_output("pair_count", got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check_output("pair_sym", int'(got[k].sym), int'(exp_q[k].sym));
            check_output("pair_cnt", int'(got[k].cnt), int'(exp_q[k].cnt));
            check_output("pair_last", int'(got_last[k]), (k == exp_q.size() - 1) ? 1 : 0);
            if (mode == 0) begin
                check_output("pair_time", got_cyc[k] - c_last, 2 + int'(exp_q[k].sym));
            end
        end
    endtask

    initial begin
        int         c_last;
        int         nd;
        int         lim;
        logic [7:0] blk [20];

        for (int i = 0; i < 20; i++) begin
            vecs[0].data[i] = 8'h41;
            vecs[1].data[i] = 8'(i);
            vecs[2].data[i] = (i < 10) ? 8'h05 : 8'hFF;
            vecs[3].data[i] = (i < 19) ? 8'h80 : 8'h00;
        end
        vecs[0].ready_mode = 0; vecs[0].exp_pairs = 1;  vecs[0].exp_first_sym = 8'h41; vecs[0].exp_first_cnt = 20;
        vecs[0].exp_first_lat = 67; vecs[0].exp_last_sym = 8'h41; vecs[0].exp_last_cnt = 20; vecs[0].exp_distinct = 1;
        vecs[1].ready_mode = 0; vecs[1].exp_pairs = 20; vecs[1].exp_first_sym = 0; vecs[1].exp_first_cnt = 1;
        vecs[1].exp_first_lat = 2; vecs[1].exp_last_sym = 8'h13; vecs[1].exp_last_cnt = 1; vecs[1].exp_distinct = 20;
        vecs[2].ready_mode = 1; vecs[2].exp_pairs = 2;  vecs[2].exp_first_sym = 8'h05; vecs[2].exp_first_cnt = 10;
        vecs[2].exp_first_lat = 7; vecs[2].exp_last_sym = 8'hFF; vecs[2].exp_last_cnt = 10; vecs[2].exp_distinct = 2;
        vecs[3].ready_mode = 0; vecs[3].exp_pairs = 2;  vecs[3].exp_first_sym = 0; vecs[3].exp_first_cnt = 1;
        vecs[3].exp_first_lat = 2; vecs[3].exp_last_sym = 8'h80; vecs[3].exp_last_cnt = 19; vecs[3].exp_distinct = 2;

        bus.in_enb    = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", int'(bus.busy), 0);
        check_output("reset_valid", int'(bus.out_valid), 0);
        check_output("reset_sym", int'(bus.out_sym), 0);
        check_output("reset_cnt", int'(bus.out_cnt), 0);
        check_output("reset_last", int'(bus.out_last), 0);
        check_output("reset_distinct", int'(bus.distinct), 0);
`ifdef HUFF_FREQ_DROP_ERR_EN
        check_output("reset_drop_err", int'(drop_err), 0);
`endif
        reset = 1'b1;
        cycle();

        // Directed rows run back to back: each block starts the cycle busy falls.
        for (int r = 0; r < 4; r++) begin
            nd = model_block(vecs[r].data);
            apply_stimulus(vecs[r].data, vecs[r].ready_mode, 1'b0, vecs[r].exp_distinct, c_last);
            check_output("vec_pairs", got.size(), vecs[r].exp_pairs);
            check_output("vec_first_lat", first_valid - c_last, vecs[r].exp_first_lat);
            if (got.size() > 0) begin
                check_output("vec_first_sym", int'(got[0].sym), vecs[r].exp_first_sym);
                check_output("vec_first_cnt", int'(got[0].cnt), vecs[r].exp_first_cnt);
                check_output("vec_last_sym", int'(got[got.size()-1].sym), vecs[r].exp_last_sym);
                check_output("vec_last_cnt", int'(got[got.size()-1].cnt), vecs[r].exp_last_cnt);
            end
            compare_model(c_last, vecs[r].ready_mode);
        end

        for (int b = 0; b < 8; b++) begin
            case (b % 3)
                0:       lim = 7;
                1:       lim = 63;
                default: lim = 255;
            endcase
            for (int i = 0; i < 20; i++) blk[i] = 8'($urandom_range(0, lim));
            nd = model_block(blk);
            apply_stimulus(blk, (b % 2 == 0) ? 0 : 2, 1'b0, nd, c_last);
            compare_model(c_last, (b % 2 == 0) ? 0 : 2);
        end

        for (int i = 0; i < 20; i++) blk[i] = 8'h10;
        nd = model_block(blk);
        apply_stimulus(blk, 0, 1'b1, nd, c_last);
        compare_model(c_last, 0);
`ifdef HUFF_FREQ_DROP_ERR_EN
        check_output("drop_err_set", int'(drop_err), 1);
`endif
        for (int i = 0; i < 20; i++) blk[i] = 8'h22;
        nd = model_block(blk);
        apply_stimulus(blk, 0, 1'b0, nd, c_last);
        compare_model(c_last, 0);

        // Reset in the middle of a scan, after two pairs have been taken.
        got.delete();
        got_cyc.delete();
        got_last.delete();
        last_seen     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_enb  = 1'b1;
            bus.in_data = 8'(i);
            cycle();
        end
        bus.in_enb = 1'b0;
        for (int n = 0; n < 50 && got.size() < 2; n++) cycle();
        check_output("pre_reset_pairs", got.size(), 2);
        reset = 1'b0;
        #1;
        check_output("midreset_busy", int'(bus.busy), 0);
        check_output("midreset_valid", int'(bus.out_valid), 0);
        check_output("midreset_sym", int'(bus.out_sym), 0);
        check_output("midreset_cnt", int'(bus.out_cnt), 0);
        check_output("midreset_last", int'(bus.out_last), 0);
        check_output("midreset_distinct", int'(bus.distinct), 0);
`ifdef HUFF_FREQ_DROP_ERR_EN
        check_output("midreset_drop_err", int'(drop_err), 0);
`endif
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check_output("post_reset_valid", int'(bus.out_valid), 0);
        for (int i = 0; i < 20; i++) blk[i] = 8'h07;
        nd = model_block(blk);
        apply_stimulus(blk, 0, 1'b0, nd, c_last);
        check_output("post_reset_pairs", got.size(), 1);
        if (got.size() > 0) begin
            check_output("post_reset_sym", int'(got[0].sym), 7);
            check_output("post_reset_cnt", int'(got[0].cnt), 20);
        end
        compare_model(c_last, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
